// File: rtl/fifo_pong_split.sv
// fifo_pong_split: one enq stream dealt strictly alternately
// into two 2-entry FIFO lanes, each with its own deq port.
module fifo_pong_split #(
  parameter int WIDTH = 704
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  input  logic             out0_deq__ENA,
  output logic             out0_deq__RDY,
  output logic [WIDTH-1:0] out0_first,
  output logic             out0_first__RDY,
  input  logic             out1_deq__ENA,
  output logic             out1_deq__RDY,
  output logic [WIDTH-1:0] out1_first,
  output logic             out1_first__RDY,
  output logic [1:0]       count0,
  output logic [1:0]       count1
);

  logic             r_sel;
  logic [1:0]       r_rp;
  logic [1:0]       r_wp;
  logic [1:0][1:0]  r_cnt;
  logic [WIDTH-1:0] r_mem [2][2];

  logic       w_enq;
  logic [1:0] w_enq_k;
  logic [1:0] w_deq_ena;
  logic [1:0] w_deq;
  logic [1:0] w_ne;

  assign w_ne[0] = (r_cnt[0] != 2'd0);
  assign w_ne[1] = (r_cnt[1] != 2'd0);

  // Strict alternation: a full target lane stalls the stream.
  assign in_enq__RDY = (r_sel ? r_cnt[1] : r_cnt[0]) != 2'd2;

  assign w_enq      = in_enq__ENA & in_enq__RDY;
  assign w_enq_k[0] = w_enq & ~r_sel;
  assign w_enq_k[1] = w_enq & r_sel;

  assign w_deq_ena = {out1_deq__ENA, out0_deq__ENA};
  assign w_deq     = w_deq_ena & w_ne;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sel <= 1'b0;
      r_rp  <= '0;
      r_wp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_enq) r_sel <= ~r_sel;
      for (int k = 0; k < 2; k++) begin
        if (w_enq_k[k]) r_wp[k] <= ~r_wp[k];
        if (w_deq[k])   r_rp[k] <= ~r_rp[k];
        r_cnt[k] <= r_cnt[k] + {1'b0, w_enq_k[k]}
                             - {1'b0, w_deq[k]};
      end
    end
  end

  // Payload storage is left unreset; cnt alone marks validity.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (w_enq_k[k]) r_mem[k][r_wp[k]] <= in_enq_v;
    end
  end

  assign out0_deq__RDY   = w_ne[0];
  assign out0_first__RDY = w_ne[0];
  assign out0_first      = w_ne[0] ? r_mem[0][r_rp[0]] : '0;

  assign out1_deq__RDY   = w_ne[1];
  assign out1_first__RDY = w_ne[1];
  assign out1_first      = w_ne[1] ? r_mem[1][r_rp[1]] : '0;

  assign count0 = r_cnt[0];
  assign count1 = r_cnt[1];

endmodule

// File: tb/tb_fifo_pong_split.sv
// tb_fifo_pong_split: directed plan scenarios plus random
// traffic, checked every cycle against a queue-based model.
module tb_fifo_pong_split;

  localparam int W = 704;
  typedef logic [W-1:0] data_t;

  logic       clk;
  logic       rst_n;
  logic       in_ena;
  data_t      in_v;
  logic       in_rdy;
  logic       d0_ena, d1_ena;
  logic       d0_rdy, d1_rdy;
  logic       f0_rdy, f1_rdy;
  data_t      f0, f1;
  logic [1:0] cnt0, cnt1;

  int checks;
  int failures;

  data_t q0[$];
  data_t q1[$];
  bit    m_sel;

  fifo_pong_split #(.WIDTH(W)) dut (
    .CLK            (clk),
    .nRST           (rst_n),
    .in_enq__ENA    (in_ena),
    .in_enq_v       (in_v),
    .in_enq__RDY    (in_rdy),
    .out0_deq__ENA  (d0_ena),
    .out0_deq__RDY  (d0_rdy),
    .out0_first     (f0),
    .out0_first__RDY(f0_rdy),
    .out1_deq__ENA  (d1_ena),
    .out1_deq__RDY  (d1_rdy),
    .out1_first     (f1),
    .out1_first__RDY(f1_rdy),
    .count0         (cnt0),
    .count1         (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input data_t obs,
                     input data_t exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_rdy();
    int sz;
    sz = m_sel ? q1.size() : q0.size();
    return sz != 2;
  endfunction

  function automatic data_t head(input bit lane);
    if (lane == 1'b0) return (q0.size() != 0) ? q0[0] : '0;
    return (q1.size() != 0) ? q1[0] : '0;
  endfunction

  task automatic check_all();
    chk("enq_rdy", data_t'(in_rdy), data_t'(m_rdy()));
    chk("deq_rdy0", data_t'(d0_rdy), data_t'(q0.size() != 0));
    chk("frst_rdy0", data_t'(f0_rdy), data_t'(q0.size() != 0));
    chk("first0", f0, head(1'b0));
    chk("count0", data_t'(cnt0), data_t'(q0.size()));
    chk("deq_rdy1", data_t'(d1_rdy), data_t'(q1.size() != 0));
    chk("frst_rdy1", data_t'(f1_rdy), data_t'(q1.size() != 0));
    chk("first1", f1, head(1'b1));
    chk("count1", data_t'(cnt1), data_t'(q1.size()));
  endtask

  function automatic void m_clear();
    q0.delete();
    q1.delete();
    m_sel = 1'b0;
  endfunction

  // One clock: drive, predict fires from model, step, compare.
  task automatic cyc(input bit e, input data_t d,
                     input bit x0, input bit x1);
    bit fe, f0x, f1x;
    in_ena = e;
    in_v   = d;
    d0_ena = x0;
    d1_ena = x1;
    fe  = e && m_rdy();
    f0x = x0 && (q0.size() != 0);
    f1x = x1 && (q1.size() != 0);
    @(posedge clk);
    #1;
    if (f0x) void'(q0.pop_front());
    if (f1x) void'(q1.pop_front());
    if (fe) begin
      if (m_sel) q1.push_back(d);
      else       q0.push_back(d);
      m_sel = ~m_sel;
    end
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic reset_sync();
    @(negedge clk);
    rst_n = 1'b0;
    m_clear();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic data_t rnd();
    data_t d;
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst_n  = 1'b0;
    in_ena = 1'b0;
    in_v   = '0;
    d0_ena = 1'b0;
    d1_ena = 1'b0;
    m_clear();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill both lanes, then drain lane 0.
    for (int i = 1; i <= 4; i++) cyc(1'b1, data_t'(i), 1'b0, 1'b0);
    chk("fill_rdy", data_t'(in_rdy), data_t'(0));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_first0", f0, data_t'(3));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty0", f0, data_t'(0));

    // Strict-order stall with lane 1 empty and lane 0 full.
    reset_sync();
    for (int i = 1; i <= 4; i++) cyc(1'b1, data_t'(i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, data_t'(99), 1'b0, 1'b0);
    chk("stall_rdy", data_t'(in_rdy), data_t'(0));
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, data_t'(5), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stall_order", f0, data_t'(5));

    // Same-cycle enq and deq on lane 0 at count 1.
    reset_sync();
    cyc(1'b1, data_t'(7), 1'b0, 1'b0);
    cyc(1'b1, data_t'(8), 1'b0, 1'b0);
    cyc(1'b1, data_t'(9), 1'b1, 1'b0);
    chk("sim_cnt0", data_t'(cnt0), data_t'(1));
    chk("sim_first0", f0, data_t'(9));

    // Deq ENA held on empty lanes.
    reset_sync();
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b1, data_t'('hAB), 1'b0, 1'b0);
    chk("empty_deq_out0", f0, data_t'('hAB));
    chk("empty_deq_cnt1", data_t'(cnt1), data_t'(0));

    // Pointer wrap through both lanes.
    reset_sync();
    for (int i = 0; i < 20; i++) cyc(1'b1, data_t'(i), 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle with count0=2, count1=1, sel=1.
    reset_sync();
    for (int i = 1; i <= 3; i++) cyc(1'b1, data_t'(i), 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    m_clear();
    #1;
    check_all();
    chk("arst_rdy", data_t'(in_rdy), data_t'(1));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, data_t'('h55), 1'b0, 1'b0);
    chk("arst_out0", f0, data_t'('h55));

    // Random traffic.
    reset_sync();
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 3) != 0), rnd(),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
